dotprod_loader: RTL

DOTPROD_LOADER -- requirements
Module: dotprod_loader

---
 rtl/dotprod_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dotprod_loader.sv
// Streams signed element pairs into the dot-product core's two arrays,
// zero-fills the unused tail of the arrays, starts the core, waits for its
// done strobe and holds the 64-bit result until the consumer takes it.
module dotprod_loader #(
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // upstream element stream
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [26:0]       in_a,
  input  logic signed [26:0]       in_b,
  input  logic                     in_last,
  // array port ownership and write ports
  output logic                     controlArr,
  output logic                     controlArrWEnable_a,
  output logic                     controlArrWEnable_b,
  output logic [ADDR_W-1:0]        controlArrAddr_a,
  output logic [ADDR_W-1:0]        controlArrAddr_b,
  output logic signed [26:0]       controlArrWData_a,
  output logic signed [26:0]       controlArrWData_b,
  // core control
  output logic                     r_enable,
  output logic [ADDR_W-1:0]        init_i_t_a,
  output logic signed [63:0]       init_acc_t_a,
  input  logic                     w_enable,
  input  logic signed [63:0]       result,
  // result handshake
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [63:0]       out_result,
  output logic [ADDR_W:0]          out_count
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    FILL  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Index register is one bit wider than the address so it can reach DEPTH,
  // which marks "every array entry has been written".
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W:0]    idx_q, idx_d;       // next array address to write
  logic [ADDR_W:0]    cnt_q, cnt_d;       // beats accepted for this vector
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic signed [26:0] wdata_a_q, wdata_a_d;
  logic signed [26:0] wdata_b_q, wdata_b_d;
  logic signed [63:0] result_q, result_d;

  // Next-state, write-port and handshake decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_a_d = wdata_a_q;
    wdata_b_d = wdata_b_q;
    result_d  = result_q;
    in_ready  = 1'b0;

    unique case (state_q)
      LOAD: begin
        // Once the entry at DEPTH-1 has been taken the loader stops accepting
        // and spends this cycle presenting that final write; START follows.
        in_ready = (idx_q != DEPTH_C);
        if (!in_ready) begin
          state_d = START;
        end else if (in_valid) begin
          we_d      = 1'b1;
          addr_d    = idx_q[ADDR_W-1:0];
          wdata_a_d = in_a;
          wdata_b_d = in_b;
          idx_d     = idx_q + ONE_C;
          cnt_d     = cnt_q + ONE_C;
          // A short vector pads the rest of the arrays with zeros; a full
          // one ignores in_last and goes straight to START.
          if (idx_q != LAST_C && in_last) begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        // One zero write per cycle up to DEPTH-1; the cycle that presents the
        // last zero write sees idx_q == DEPTH and moves on.
        if (idx_q != DEPTH_C) begin
          we_d      = 1'b1;
          addr_d    = idx_q[ADDR_W-1:0];
          wdata_a_d = '0;
          wdata_b_d = '0;
          idx_d     = idx_q + ONE_C;
        end else begin
          state_d = START;
        end
      end

      START: begin
        state_d = RUN;
      end

      RUN: begin
        if (w_enable) begin
          result_d = result;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, index, write-port and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_a_q <= wdata_a_d;
      wdata_b_q <= wdata_b_d;
      result_q  <= result_d;
    end
  end

  // Both arrays are always written together with the same address.
  assign controlArrWEnable_a = we_q;
  assign controlArrWEnable_b = we_q;
  assign controlArrAddr_a    = addr_q;
  assign controlArrAddr_b    = addr_q;
  assign controlArrWData_a   = wdata_a_q;
  assign controlArrWData_b   = wdata_b_q;

  assign controlArr   = (state_q == LOAD) || (state_q == FILL);
  assign r_enable     = (state_q == START);
  assign out_valid    = (state_q == DONE);
  assign out_result   = result_q;
  assign out_count    = cnt_q;

  // The core always starts from index 0 with a cleared accumulator.
  assign init_i_t_a   = '0;
  assign init_acc_t_a = '0;

endmodule
